// File: rtl/burst_line_writer_if.sv
// Client line-write port and BurstRAM write-command port of burst_line_writer.
// slave = the writer itself, master = client plus BurstRAM side.
interface burst_line_writer_if #(
   parameter int RDB   = 8,
   parameter int COUNT = 4,
   parameter int BW    = 64
);
   localparam int LINE = COUNT * BW;
   localparam int STRB = LINE / 8;
   localparam int BS   = BW / 8;

   logic            wr_req;
   logic [RDB-1:0]  wr_addr;
   logic [LINE-1:0] wr_line;
   logic [STRB-1:0] wr_strb;
   logic            wr_rdy;
   logic            wr_done;
   logic            idle;
   logic            br_cmd;
   logic            br_cmd_en;
   logic [RDB-1:0]  br_addr;
   logic [BW-1:0]   br_wr_data;
   logic [BS-1:0]   br_data_mask;
   logic            br_busy;

   modport slave (
      input  wr_req, wr_addr, wr_line, wr_strb, br_busy,
      output wr_rdy, wr_done, idle,
      output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

   modport master (
      output wr_req, wr_addr, wr_line, wr_strb, br_busy,
      input  wr_rdy, wr_done, idle,
      input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );
endinterface

// File: rtl/burst_line_writer.sv
// Cache-line write-back initiator: one pending line slot feeding a
// BurstRAM write burst of RAM_BURST_DATA_COUNT beats per line.
module burst_line_writer #(
   parameter int RAM_DEPTH_BITWIDTH      = 8,
   parameter int RAM_BURST_DATA_COUNT    = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
   input logic                  clk,
   input logic                  rst,
   burst_line_writer_if.slave   bus
);
   localparam int RDB  = RAM_DEPTH_BITWIDTH;
   localparam int CNT  = RAM_BURST_DATA_COUNT;
   localparam int BW   = RAM_BURST_DATA_BITWIDTH;
   localparam int LINE = CNT * BW;
   localparam int STRB = LINE / 8;
   localparam int BS   = BW / 8;
   localparam int CB   = $clog2(CNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BURST
   } state_e;

   state_e          state_q, state_d;
   logic            full_q, full_d;
   logic [RDB-1:0]  saddr_q, saddr_d;
   logic [LINE-1:0] sline_q, sline_d;
   logic [STRB-1:0] sstrb_q, sstrb_d;
   logic [LINE-1:0] sh_q, sh_d;
   logic [STRB-1:0] shm_q, shm_d;
   logic [CB-1:0]   beat_q, beat_d;
   logic            fin_q, fin_d;
   logic            done_q, done_d;
   logic            cmd_en_q, cmd_en_d;
   logic [RDB-1:0]  addr_q, addr_d;
   logic [BW-1:0]   data_q, data_d;
   logic [BS-1:0]   mask_q, mask_d;

   logic accept;
   logic go;
   logic burst;
   logic skip;
   logic last;

   assign accept = bus.wr_req && !full_q;
   assign go     = (state_q == S_ISSUE) && !bus.br_busy;
   assign burst  = (state_q == S_BURST);
   assign last   = (beat_q == CB'(CNT - 1));
   // Empty-strobe lines complete without a burst; wait out a pending
   // done so the two pulses never merge.
   assign skip   = (state_q == S_IDLE) && full_q && !fin_q
                   && (sstrb_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (full_q && (sstrb_q != '0)) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (!bus.br_busy) state_d = S_BURST;
         end
         S_BURST: begin
            if (last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      full_d   = full_q;
      saddr_d  = saddr_q;
      sline_d  = sline_q;
      sstrb_d  = sstrb_q;
      sh_d     = sh_q;
      shm_d    = shm_q;
      beat_d   = beat_q;
      fin_d    = 1'b0;
      done_d   = fin_q;
      cmd_en_d = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      mask_d   = '1;
      if (accept) begin
         full_d  = 1'b1;
         saddr_d = bus.wr_addr & ~RDB'(CNT - 1);
         sline_d = bus.wr_line;
         sstrb_d = bus.wr_strb;
      end
      unique case (1'b1)
         go: begin
            full_d   = 1'b0;
            cmd_en_d = 1'b1;
            addr_d   = saddr_q;
            data_d   = sline_q[BW-1:0];
            mask_d   = ~sstrb_q[BS-1:0];
            sh_d     = sline_q >> BW;
            shm_d    = sstrb_q >> BS;
            beat_d   = CB'(1);
         end
         burst: begin
            data_d = sh_q[BW-1:0];
            mask_d = ~shm_q[BS-1:0];
            sh_d   = sh_q >> BW;
            shm_d  = shm_q >> BS;
            beat_d = beat_q + CB'(1);
            fin_d  = last;
         end
         skip: begin
            full_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q   <= 1'b0;
         saddr_q  <= '0;
         sline_q  <= '0;
         sstrb_q  <= '0;
         sh_q     <= '0;
         shm_q    <= '0;
         beat_q   <= '0;
         fin_q    <= 1'b0;
         done_q   <= 1'b0;
         cmd_en_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         mask_q   <= '1;
      end else begin
         full_q   <= full_d;
         saddr_q  <= saddr_d;
         sline_q  <= sline_d;
         sstrb_q  <= sstrb_d;
         sh_q     <= sh_d;
         shm_q    <= shm_d;
         beat_q   <= beat_d;
         fin_q    <= fin_d;
         done_q   <= done_d;
         cmd_en_q <= cmd_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         mask_q   <= mask_d;
      end
   end

   assign bus.wr_rdy       = !full_q;
   assign bus.wr_done      = done_q;
   assign bus.idle         = !full_q && (state_q == S_IDLE) && !fin_q;
   assign bus.br_cmd       = cmd_en_q;
   assign bus.br_cmd_en    = cmd_en_q;
   assign bus.br_addr      = addr_q;
   assign bus.br_wr_data   = data_q;
   assign bus.br_data_mask = mask_q;
endmodule

// File: tb/tb_burst_line_writer.sv
// Directed bench for burst_line_writer with a small BurstRAM write model.
// Expected values are hand-computed per test.
module tb_burst_line_writer;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   burst_line_writer_if #(.RDB(8), .COUNT(4), .BW(64)) bus ();

   burst_line_writer #(
      .RAM_DEPTH_BITWIDTH(8),
      .RAM_BURST_DATA_COUNT(4),
      .RAM_BURST_DATA_BITWIDTH(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [63:0] mem [256];
   int          n_en = 0;
   int          n_done = 0;
   int          en_cyc [16];
   logic [7:0]  en_addr [16];
   logic        en_cmd [16];
   int          lb [16];
   int          done_cyc [16];
   logic [63:0] bd [4];
   logic [7:0]  bm [4];
   int          bi = 0;
   bit          act = 0;
   logic [7:0]  base;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mk(input logic [63:0] b);
      return {b + 64'd3, b + 64'd2, b + 64'd1, b};
   endfunction

   // BurstRAM write model and event log
   always @(negedge clk) begin
      if (!rst) begin
         act = 0;
      end else begin
         if (bus.br_cmd_en) begin
            en_cyc[n_en]  = cyc;
            en_addr[n_en] = bus.br_addr;
            en_cmd[n_en]  = bus.br_cmd;
            n_en++;
            act  = 1;
            bi   = 0;
            base = bus.br_addr;
         end
         if (act) begin
            bd[bi] = bus.br_wr_data;
            bm[bi] = bus.br_data_mask;
            for (int b = 0; b < 8; b++)
               if (!bus.br_data_mask[b])
                  mem[base + 8'(bi)][8*b +: 8] = bus.br_wr_data[8*b +: 8];
            if (bi == 3) begin
               act = 0;
               lb[n_en-1] = cyc;
            end
            bi++;
         end
         if (bus.wr_done) begin
            done_cyc[n_done] = cyc;
            n_done++;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [255:0] l,
                       input logic [31:0] s);
      int n = 0;
      @(negedge clk);
      bus.wr_req  = 1'b1;
      bus.wr_addr = a;
      bus.wr_line = l;
      bus.wr_strb = s;
      while (!bus.wr_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_rdy", bus.wr_rdy, 1);
      @(negedge clk);
      bus.wr_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(bus.idle && !bus.wr_done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_wait", bus.idle, 1);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cmd(input string tag);
      int n = 0;
      while (!bus.br_cmd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, bus.br_cmd_en, 1);
   endtask

   initial begin
      int e, d, t, rel;
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, d, t, rel;
      for (int i = 0; i < 256; i++)
         mem[i] = 64'hAAAA_AAAA_AAAA_AA00 | 64'(i);
      rst          = 1'b0;
      bus.wr_req   = 1'b1;
      bus.wr_addr  = 8'h00;
      bus.wr_line  = '0;
      bus.wr_strb  = '1;
      bus.br_busy  = 1'b0;

      // T1 reset with request held
      repeat (3) begin
         @(negedge clk);
         check("t1_en_rst", bus.br_cmd_en, 0);
         check("t1_rdy_rst", bus.wr_rdy, 1);
      end
      rst        = 1'b1;
      bus.wr_req = 1'b0;
      @(negedge clk);
      check("t1_rdy", bus.wr_rdy, 1);
      check("t1_mask", bus.br_data_mask, 8'hFF);
      check("t1_idle", bus.idle, 1);
      check("t1_done", bus.wr_done, 0);
      check("t1_addr", bus.br_addr, 8'h00);
      check("t1_data", bus.br_wr_data, 64'h0);
      check("t1_nen", n_en, 0);

      // T2 full line
      e = n_en; d = n_done;
      send(8'h10, mk(64'h0), '1);
      wait_idle();
      check("t2_nen", n_en, e + 1);
      check("t2_addr", en_addr[e], 8'h10);
      check("t2_cmd", en_cmd[e], 1);
      for (int k = 0; k < 4; k++) begin
         check("t2_beat", bd[k], 64'(k));
         check("t2_mask", bm[k], 8'h00);
         check("t2_mem", mem[8'h10 + k], 64'(k));
      end
      check("t2_ndone", n_done, d + 1);
      check("t2_done_cyc", done_cyc[d], en_cyc[e] + 4);

      // T3 masked, unaligned address
      e = n_en;
      send(8'h13, {64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                   64'hDDDD_DDDD_DDDD_DDDD, 64'h1122_3344_5566_7788},
           32'h0000_00F0);
      wait_idle();
      check("t3_addr", en_addr[e], 8'h10);
      check("t3_mask0", bm[0], 8'h0F);
      check("t3_mask1", bm[1], 8'hFF);
      check("t3_mask2", bm[2], 8'hFF);
      check("t3_mask3", bm[3], 8'hFF);
      check("t3_mem10", mem[8'h10], 64'h1122_3344_0000_0000);
      check("t3_mem11", mem[8'h11], 64'h1);

      // T4 busy stall
      e = n_en; d = n_done;
      bus.br_busy = 1'b1;
      send(8'h20, mk(64'h100), '1);
      repeat (4) @(negedge clk);
      check("t4_nen_stall", n_en, e);
      bus.br_busy = 1'b0;
      rel = cyc;
      wait_idle();
      check("t4_nen", n_en, e + 1);
      check("t4_en_cyc", en_cyc[e], rel + 1);
      check("t4_beat3", bd[3], 64'h103);
      check("t4_done_cyc", done_cyc[d], en_cyc[e] + 4);
      check("t4_mem21", mem[8'h21], 64'h101);

      // T5 queueing during a burst
      e = n_en; d = n_done;
      send(8'h30, mk(64'h30), '1);
      wait_cmd("t5_cmda");
      check("t5_rdy_burst", bus.wr_rdy, 1);
      send(8'h34, mk(64'h40), '1);
      bus.wr_req  = 1'b1;
      bus.wr_addr = 8'h38;
      bus.wr_line = mk(64'h60);
      check("t5_refuse0", bus.wr_rdy, 0);
      @(negedge clk);
      check("t5_refuse1", bus.wr_rdy, 0);
      bus.wr_req = 1'b0;
      wait_idle();
      check("t5_nen", n_en, e + 2);
      check("t5_addr_b", en_addr[e+1], 8'h34);
      check("t5_gap", en_cyc[e+1], lb[e] + 2);
      check("t5_ndone", n_done, d + 2);
      check("t5_done_a", done_cyc[d], lb[e] + 1);
      check("t5_done_b", done_cyc[d+1], lb[e+1] + 1);
      check("t5_mem33", mem[8'h33], 64'h33);
      check("t5_mem37", mem[8'h37], 64'h43);
      check("t5_mem38", mem[8'h38], 64'hAAAA_AAAA_AAAA_AA38);

      // T6 zero strobe
      e = n_en; d = n_done;
      send(8'h40, mk(64'h70), 32'h0);
      t = cyc;
      wait_idle();
      check("t6_nen", n_en, e);
      check("t6_ndone", n_done, d + 1);
      check("t6_done_cyc", done_cyc[d], t + 1);
      check("t6_mem40", mem[8'h40], 64'hAAAA_AAAA_AAAA_AA40);

      // T6 reset during beat 2
      e = n_en; d = n_done;
      send(8'h50, mk(64'h50), '1);
      wait_cmd("t6_cmdd");
      @(negedge clk);
      @(negedge clk);
      check("t6_beat2", bus.br_wr_data, 64'h52);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_en", bus.br_cmd_en, 0);
      check("t6_rst_mask", bus.br_data_mask, 8'hFF);
      check("t6_rst_data", bus.br_wr_data, 64'h0);
      check("t6_rst_addr", bus.br_addr, 8'h00);
      check("t6_rst_rdy", bus.wr_rdy, 1);
      check("t6_rst_idle", bus.idle, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("t6_no_done", n_done, d);
      check("t6_no_cmd", n_en, e + 1);
      check("t6_rdy_end", bus.wr_rdy, 1);
      check("t6_idle_end", bus.idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
